// File: rtl/four_phase_pkg.sv
// Shared definitions for the four-phase round-robin arbiter.
//   - State encoding of the arbiter FSM (fixed numeric values, also exposed
//     as an enum for readable FSM code).
//   - Default synchronizer depth used when the top is instantiated bare.
package four_phase_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ_UP = 2'd1;
  localparam logic [1:0] ST_ACK_UP = 2'd2;
  localparam logic [1:0] ST_REQ_DN = 2'd3;

  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_REQ_UP = ST_REQ_UP,
    S_ACK_UP = ST_ACK_UP,
    S_REQ_DN = ST_REQ_DN
  } state_e;

endpackage

// File: rtl/four_phase_sync.sv
// Multi-bit flip-flop synchronizer with asynchronous active-low clear.
// Each bit is synchronized independently; STAGES=0 turns the block into a
// plain wire for inputs that are already synchronous to clk.
// Ports:
//   clk   - destination clock
//   rstn  - asynchronous active-low clear of every stage
//   d     - asynchronous input bits
//   q     - synchronized bits (STAGES cycles later)
module four_phase_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_rstn;
      assign unused_clk_rstn = clk ^ rstn;
      assign q = d;
    end else begin : g_flops
      logic [STAGES-1:0][WIDTH-1:0] stg;

      // NOTE: every stage is cleared on reset so a request or acknowledge
      // captured before reset can never surface afterwards as a phantom edge.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          stg <= '0;
        end else begin
          // NOTE: non-blocking assignments make the stages shift by exactly
          // one position per clock regardless of statement order.
          stg[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            stg[i] <= stg[i-1];
          end
        end
      end

      assign q = stg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/four_phase_arbiter.sv
// Round-robin arbiter sharing one downstream four-phase req/ack channel
// between N upstream four-phase requesters. Every output is a flop; the FSM
// only looks at synchronized copies of req_in and ack_out.
// Ports:
//   clk       - block clock
//   rstn      - asynchronous active-low reset (aborts any handshake)
//   req_in    - four-phase requests from the N requesters
//   ack_in    - four-phase acknowledges back to the requesters
//   req_out   - four-phase request to the shared resource
//   ack_out   - four-phase acknowledge from the shared resource
//   grant     - one-hot owner, zero when idle
//   grant_idx - encoded owner, valid while busy
//   busy      - high from grant until the owner's ack_in returns low
module four_phase_arbiter
  import four_phase_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int IDX_W       = $clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req_in,
  output logic [N-1:0]     ack_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);

  logic [N-1:0] rq_s;
  logic         ak_s;

  four_phase_sync #(.STAGES(SYNC_STAGES), .WIDTH(N)) u_sync_req (
    .clk  (clk),
    .rstn (rstn),
    .d    (req_in),
    .q    (rq_s)
  );

  four_phase_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_ack (
    .clk  (clk),
    .rstn (rstn),
    .d    (ack_out),
    .q    (ak_s)
  );

  // Wrap-around increment of an owner index (N need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // First set request at or after `start`, searching upward modulo N.
  // Only called when at least one request bit is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     req,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick;
    logic             found;
    cand  = start;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = next_idx(cand);
    end
    return pick;
  endfunction

  state_e           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] idx_n;
  logic [N-1:0]     grant_n, ack_n;
  logic             busy_n, req_out_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      grant     <= '0;
      ack_in    <= '0;
      busy      <= 1'b0;
      req_out   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_idx <= idx_n;
      grant     <= grant_n;
      ack_in    <= ack_n;
      busy      <= busy_n;
      req_out   <= req_out_n;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_n   = state;
    ptr_n     = ptr;
    idx_n     = grant_idx;
    grant_n   = grant;
    ack_n     = ack_in;
    busy_n    = busy;
    req_out_n = req_out;

    unique case (state)
      S_IDLE: begin
        // A stale high acknowledge blocks a new grant until it clears.
        if ((|rq_s) && !ak_s) begin
          idx_n          = rr_pick(rq_s, ptr);
          grant_n        = '0;
          grant_n[idx_n] = 1'b1;
          busy_n         = 1'b1;
          req_out_n      = 1'b1;
          state_n        = S_REQ_UP;
        end
      end
      S_REQ_UP: begin
        // The owner's request is not looked at here: an early drop is
        // deferred to ACK_UP and the handshake still completes.
        if (ak_s) begin
          ack_n[grant_idx] = 1'b1;
          state_n          = S_ACK_UP;
        end
      end
      S_ACK_UP: begin
        // A premature ack_out fall is ignored; only the owner's release
        // moves the handshake on.
        if (!rq_s[grant_idx]) begin
          req_out_n = 1'b0;
          state_n   = S_REQ_DN;
        end
      end
      S_REQ_DN: begin
        if (!ak_s) begin
          ack_n   = '0;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = next_idx(grant_idx);
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_four_phase_arbiter.sv
// Self-checking bench for four_phase_arbiter (N=4, two sync stages), plus a
// second instance in bypass mode (no synchronizer) for latency checks.
// A handshake-level reference model is fed with the input values the
// arbiter sees after synchronization and compared every cycle.
module tb_four_phase_arbiter;

  localparam int N     = 4;
  localparam int S     = 2;
  localparam int IDX_W = $clog2(N);

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic [N-1:0]     req_in  = '0;
  logic             ack_out = 1'b0;
  logic [N-1:0]     ack_in, grant;
  logic             req_out, busy;
  logic [IDX_W-1:0] grant_idx;

  logic [N-1:0]     reqb = '0;
  logic             ackb = 1'b0;
  logic [N-1:0]     ack_in_b, grant_b;
  logic             req_out_b, busy_b;
  logic [IDX_W-1:0] grant_idx_b;

  four_phase_arbiter #(.N(N), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_in    (req_in),
    .ack_in    (ack_in),
    .req_out   (req_out),
    .ack_out   (ack_out),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  four_phase_arbiter #(.N(N), .SYNC_STAGES(0)) dut_byp (
    .clk       (clk),
    .rstn      (rstn),
    .req_in    (reqb),
    .ack_in    (ack_in_b),
    .req_out   (req_out_b),
    .ack_out   (ackb),
    .grant     (grant_b),
    .grant_idx (grant_idx_b),
    .busy      (busy_b)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (handshake level) ----------------
  logic [N:0] hist[$];      // {req_in, ack_out} present at each clock edge
  int  m_owner   = -1;      // -1 when idle
  int  m_ptr     = 0;
  bit  m_acked   = 1'b0;
  bit  m_dropped = 1'b0;

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic model_update(input logic [N-1:0] rq, input logic ak);
    int c;
    bit found;
    found = 1'b0;
    if (m_owner < 0) begin
      if (rq != '0 && !ak) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && bit_at(rq, c)) begin
            found   = 1'b1;
            m_owner = c;
          end
        end
        m_acked   = 1'b0;
        m_dropped = 1'b0;
      end
    end else if (!m_acked) begin
      if (ak) m_acked = 1'b1;
    end else if (!m_dropped) begin
      if (!bit_at(rq, m_owner)) m_dropped = 1'b1;
    end else if (!ak) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  // ---------------- environment agents ----------------
  bit [N-1:0] req_auto    = '0;
  bit         rsp_auto    = 1'b0;
  bit         rand_mode   = 1'b0;
  bit         withdraw_en = 1'b0;
  int         want[N];
  int         hold[N];
  int         gap[N];
  int         rsp_wait    = 0;
  bit         busy_prev   = 1'b0;
  int         order[$];
  int         exp_order[$];

  function automatic int want_sum();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += want[i];
    return s;
  endfunction

  // One clock: observe after the falling edge, step the model, compare,
  // then let the agents drive the inputs for the next rising edge.
  task automatic step();
    logic [N:0]   smp;
    logic [N-1:0] e_grant, e_ack;
    @(negedge clk);
    cyc++;
    hist.push_back({req_in, ack_out});
    smp = (hist.size() > S) ? hist[hist.size() - 1 - S] : '0;
    model_update(smp[N:1], smp[0]);

    e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_ack   = m_acked ? e_grant : '0;
    check("grant",   32'(grant),   32'(e_grant));
    check("ack_in",  32'(ack_in),  32'(e_ack));
    check("busy",    32'(busy),    32'(m_owner >= 0));
    check("req_out", 32'(req_out), 32'(m_owner >= 0 && !m_dropped));
    if (m_owner >= 0) check("grant_idx", 32'(grant_idx), 32'(m_owner));
    check("grant_onehot0", 32'($onehot0(grant)), 32'(1));
    check("ack_onehot0",   32'($onehot0(ack_in)), 32'(1));

    if (busy && !busy_prev) order.push_back(int'(grant_idx));
    busy_prev = busy;

    for (int i = 0; i < N; i++) begin
      logic [IDX_W-1:0] b;
      b = i[IDX_W-1:0];
      if (req_auto[b]) begin
        if (req_in[b] && ack_in[b]) begin
          if (hold[i] > 0) hold[i]--;
          else req_in[b] = 1'b0;
        end else if (!req_in[b] && !ack_in[b] && want[i] > 0) begin
          if (gap[i] > 0) begin
            gap[i]--;
          end else begin
            req_in[b] = 1'b1;
            want[i]--;
            hold[i] = rand_mode ? int'($urandom_range(0, 4)) : 0;
            gap[i]  = rand_mode ? int'($urandom_range(0, 6)) : 0;
          end
        end else if (withdraw_en && req_in[b] && !ack_in[b] && !grant[b] &&
                     $urandom_range(0, 40) == 0) begin
          req_in[b] = 1'b0;
          want[i]++;
        end
      end
    end

    if (rsp_auto && (req_out != ack_out)) begin
      if (rsp_wait > 0) begin
        rsp_wait--;
      end else begin
        ack_out  = req_out;
        rsp_wait = rand_mode ? int'($urandom_range(0, 5)) : 0;
      end
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return req_out;
      1:       return |ack_in;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input logic val,
                          input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sel(which) !== val && n < limit);
    check(tag, 32'(sel(which)), 32'(val));
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while (n < limit && !(want_sum() == 0 && req_in == '0 && !ack_out && !busy)) begin
      step();
      n++;
    end
    repeat (S + 2) step();
    check(tag, 32'({busy, ack_out, req_in}), 32'(0));
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, 32'(order.size()), 32'(exp_order.size()));
    for (int k = 0; k < exp_order.size() && k < order.size(); k++)
      check(tag, 32'(order[k]), 32'(exp_order[k]));
    order.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn      = 1'b1;
    hist.delete();
    order.delete();
    m_owner   = -1;
    m_ptr     = 0;
    m_acked   = 1'b0;
    m_dropped = 1'b0;
    busy_prev = 1'b0;
    rsp_wait  = 0;
  endtask

  initial begin : main
    int n;
    for (int i = 0; i < N; i++) begin
      want[i] = 0;
      hold[i] = 0;
      gap[i]  = 0;
    end
    do_reset();
    check("reset_outputs",     32'({grant, grant_idx, busy, req_out, ack_in}), 32'(0));
    check("reset_outputs_byp", 32'({grant_b, grant_idx_b, busy_b, req_out_b, ack_in_b}), 32'(0));

    // Bypass instance: every phase appears one clock after its input edge.
    reqb[2] = 1'b1;
    step();
    check("byp_req_up", 32'(req_out_b),   32'(1));
    check("byp_grant",  32'(grant_b),     32'(4'b0100));
    check("byp_idx",    32'(grant_idx_b), 32'(2));
    ackb = 1'b1;
    step();
    check("byp_ack_up", 32'(ack_in_b), 32'(4'b0100));
    reqb[2] = 1'b0;
    step();
    check("byp_req_dn", 32'(req_out_b), 32'(0));
    ackb = 1'b0;
    step();
    check("byp_ack_dn", 32'({ack_in_b, busy_b, grant_b}), 32'(0));

    // Single requester, resource acknowledges 3 cycles after req_out.
    req_in[1] = 1'b1;
    wait_for("req_up", 0, 1'b1, 20, n);
    check("lat_req_up", 32'(n), 32'(S + 1));
    check("single_grant", 32'(grant),     32'(4'b0010));
    check("single_idx",   32'(grant_idx), 32'(1));
    repeat (3) step();
    ack_out = 1'b1;
    wait_for("ack_up", 1, 1'b1, 20, n);
    check("lat_ack_up", 32'(n), 32'(S + 1));
    req_in[1] = 1'b0;
    wait_for("req_dn", 0, 1'b0, 20, n);
    check("lat_req_dn", 32'(n), 32'(S + 1));
    ack_out = 1'b0;
    wait_for("ack_dn", 1, 1'b0, 20, n);
    check("lat_ack_dn", 32'(n), 32'(S + 1));
    check("single_done", 32'({busy, grant}), 32'(0));
    order.delete();

    // Pointer now at 2: requests {1,2} together serve 2 first.
    req_auto = '1;
    rsp_auto = 1'b1;
    want = '{0, 1, 1, 0};
    drain("drain_ptr2", 500);
    exp_order = '{2, 1};
    check_order("order_ptr2");

    // Serve 2 alone to move the pointer to 3, then wrap 3 -> 0.
    want = '{0, 0, 1, 0};
    drain("drain_to3", 500);
    exp_order = '{2};
    check_order("order_to3");
    want = '{1, 0, 0, 1};
    drain("drain_wrap", 500);
    exp_order = '{3, 0};
    check_order("order_wrap");

    // Reset while the owner is in ACK_UP: outputs drop in the same timestep.
    req_auto  = '0;
    rsp_auto  = 1'b0;
    req_in[1] = 1'b1;
    wait_for("mid_req_up", 0, 1'b1, 20, n);
    ack_out = 1'b1;
    wait_for("mid_ack_up", 1, 1'b1, 20, n);
    #1 rstn = 1'b0;
    #1 check("rst_async", 32'({grant, grant_idx, busy, req_out, ack_in}), 32'(0));
    req_in  = '0;
    ack_out = 1'b0;
    do_reset();
    req_auto = '1;
    rsp_auto = 1'b1;
    want = '{1, 0, 0, 1};
    drain("drain_after_rst", 500);
    exp_order = '{0, 3};
    check_order("order_after_rst");

    // All four request together; requester 0 comes back for a second turn.
    want = '{2, 1, 1, 1};
    drain("drain_all", 1000);
    exp_order = '{0, 1, 2, 3, 0};
    check_order("order_all");

    // Stale acknowledge present at reset release blocks arbitration.
    req_auto = '0;
    rsp_auto = 1'b0;
    ack_out  = 1'b1;
    req_in   = 4'b0001;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      check("stale_hold", 32'(req_out), 32'(0));
    end
    ack_out = 1'b0;
    wait_for("stale_grant", 0, 1'b1, 20, n);
    check("stale_idx", 32'(grant_idx), 32'(0));
    req_auto = '1;
    rsp_auto = 1'b1;
    drain("drain_stale", 200);
    order.delete();

    // Random traffic with random delays and occasional early withdrawals.
    rand_mode   = 1'b1;
    withdraw_en = 1'b1;
    for (int i = 0; i < N; i++) want[i] = int'($urandom_range(40, 70));
    drain("drain_random", 40000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
